// File: rtl/pd_seq_pkg.sv
// Shared definitions for the power-domain sequencer: state encoding,
// parameter defaults and the counter-sizing helper.
package pd_seq_pkg;

   localparam int ISO_SETUP_DEF   = 2;
   localparam int ACK_TIMEOUT_DEF = 64;
   localparam int RST_CYCLES_DEF  = 4;

   typedef enum logic [3:0] {
      S_OFF     = 4'd0,
      S_SW_ON   = 4'd1,
      S_DRST    = 4'd2,
      S_RESTORE = 4'd3,
      S_ISO_OFF = 4'd4,
      S_ON      = 4'd5,
      S_ISO_ON  = 4'd6,
      S_SAVE    = 4'd7,
      S_SW_OFF  = 4'd8,
      S_ERR     = 4'd9
   } pd_state_e;

   // Largest of three hold/timeout lengths; sizes the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pd_seq_timer.sv
// Loadable down-counter. A load sets the count; otherwise it decrements
// until it reaches zero and holds there. done is high while count is zero.
module pd_seq_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         done
);

   // Count register: load has priority over the decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/pd_seq_ctrl.sv
// Power-domain sequencer: switch on, reset, restore, release isolation;
// and in the other direction isolate, save, switch off. Switch acknowledge
// timeouts land in a sticky error state cleared by err_clr.
// A timed state of length N is loaded with N-1 on entry and left when the
// counter reads zero, so it occupies exactly N cycles (N must be >= 1).
// All outputs are decoded from the next state and registered, so they
// change on the same edge as the state.
module pd_seq_ctrl
   import pd_seq_pkg::*;
#(
   parameter int ISO_SETUP   = ISO_SETUP_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int RST_CYCLES  = RST_CYCLES_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      pwr_on_req,
   input  logic      sw_ack,
   input  logic      err_clr,
   output logic      top_pwr_sw,
   output logic      iso_en,
   output logic      save,
   output logic      restore,
   output logic      dom_rst_n,
   output logic      busy,
   output logic      pwr_on,
   output logic      err,
   output pd_state_e dbg_state
);

   localparam int CW = $clog2(max3(ACK_TIMEOUT, RST_CYCLES, ISO_SETUP) + 1);

   pd_state_e state, next_state;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic [CW-1:0] tmr_count;
   logic          tmr_done;

   logic top_pwr_sw_d, iso_en_d, save_d, restore_d;
   logic dom_rst_n_d, busy_d, pwr_on_d, err_d;

   pd_seq_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .done     (tmr_done)
   );

   // State register and registered outputs; reset aborts any sequence.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_OFF;
         top_pwr_sw <= 1'b0;
         iso_en     <= 1'b1;
         save       <= 1'b0;
         restore    <= 1'b0;
         dom_rst_n  <= 1'b0;
         busy       <= 1'b0;
         pwr_on     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= next_state;
         top_pwr_sw <= top_pwr_sw_d;
         iso_en     <= iso_en_d;
         save       <= save_d;
         restore    <= restore_d;
         dom_rst_n  <= dom_rst_n_d;
         busy       <= busy_d;
         pwr_on     <= pwr_on_d;
         err        <= err_d;
      end
   end

   assign dbg_state = state;

   // Next-state logic plus timer reload on every state change.
   always_comb begin
      next_state = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      case (state)
         S_OFF:     if (pwr_on_req)  next_state = S_SW_ON;
         S_SW_ON: begin
            if (sw_ack)        next_state = S_DRST;
            else if (tmr_done) next_state = S_ERR;
         end
         S_DRST:    if (tmr_done)    next_state = S_RESTORE;
         S_RESTORE:                  next_state = S_ISO_OFF;
         S_ISO_OFF:                  next_state = S_ON;
         S_ON:      if (!pwr_on_req) next_state = S_ISO_ON;
         S_ISO_ON:  if (tmr_done)    next_state = S_SAVE;
         S_SAVE:                     next_state = S_SW_OFF;
         S_SW_OFF: begin
            if (!sw_ack)       next_state = S_OFF;
            else if (tmr_done) next_state = S_ERR;
         end
         S_ERR:     if (err_clr)     next_state = S_OFF;
         default:                    next_state = S_OFF;
      endcase
      if (next_state != state) begin
         tmr_load = 1'b1;
         case (next_state)
            S_SW_ON, S_SW_OFF: tmr_val = CW'(ACK_TIMEOUT - 1);
            S_DRST:            tmr_val = CW'(RST_CYCLES - 1);
            S_ISO_ON:          tmr_val = CW'(ISO_SETUP - 1);
            default:           tmr_val = '0;
         endcase
      end
   end

   // Output decode from the state being entered (isolation on by default).
   always_comb begin
      top_pwr_sw_d = 1'b0;
      iso_en_d     = 1'b1;
      save_d       = 1'b0;
      restore_d    = 1'b0;
      dom_rst_n_d  = 1'b0;
      busy_d       = 1'b0;
      pwr_on_d     = 1'b0;
      err_d        = 1'b0;
      case (next_state)
         S_SW_ON, S_DRST: begin
            top_pwr_sw_d = 1'b1;
            busy_d       = 1'b1;
         end
         S_RESTORE: begin
            top_pwr_sw_d = 1'b1;
            dom_rst_n_d  = 1'b1;
            restore_d    = 1'b1;
            busy_d       = 1'b1;
         end
         S_ISO_OFF: begin
            top_pwr_sw_d = 1'b1;
            dom_rst_n_d  = 1'b1;
            iso_en_d     = 1'b0;
            busy_d       = 1'b1;
         end
         S_ON: begin
            top_pwr_sw_d = 1'b1;
            dom_rst_n_d  = 1'b1;
            iso_en_d     = 1'b0;
            pwr_on_d     = 1'b1;
         end
         S_ISO_ON: begin
            top_pwr_sw_d = 1'b1;
            dom_rst_n_d  = 1'b1;
            busy_d       = 1'b1;
         end
         S_SAVE: begin
            top_pwr_sw_d = 1'b1;
            dom_rst_n_d  = 1'b1;
            save_d       = 1'b1;
            busy_d       = 1'b1;
         end
         S_SW_OFF:          busy_d = 1'b1;
         S_ERR:             err_d  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/pd_seq_ctrl.md
PD_SEQ_CTRL -- requirements
Module: pd_seq_ctrl

Interface
REQ-001 SHALL have parameter ISO_SETUP, default 2: cycles iso_en is held before save.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64: maximum cycles to wait for a switch acknowledge.
REQ-003 SHALL have parameter RST_CYCLES, default 4: cycles domain reset is held low after power-up.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port pwr_on_req, input, 1 bit: level request, 1 = domain on, 0 = domain off.
REQ-007 SHALL have port sw_ack, input, 1 bit: switch status from the power switch, 1 = domain supplied.
REQ-008 SHALL have port err_clr, input, 1 bit: one-cycle pulse that clears the error state.
REQ-009 SHALL have port top_pwr_sw, output, 1 bit: power switch enable.
REQ-010 SHALL have port iso_en, output, 1 bit: isolation enable for the domain outputs.
REQ-011 SHALL have port save, output, 1 bit: one-cycle retention save pulse.
REQ-012 SHALL have port restore, output, 1 bit: one-cycle retention restore pulse.
REQ-013 SHALL have port dom_rst_n, output, 1 bit: active-low reset to the switched domain.
REQ-014 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-015 SHALL have port pwr_on, output, 1 bit: domain is fully on, with isolation released.
REQ-016 SHALL have port err, output, 1 bit: sticky switch timeout error.

Function
REQ-017 SHALL implement the states OFF, SW_ON, DRST, RESTORE, ISO_OFF, ON, ISO_ON, SAVE, SW_OFF and ERR; all outputs SHALL be registered.
REQ-018 In OFF with pwr_on_req=1 sampled, SHALL go to SW_ON next cycle, asserting top_pwr_sw=1 and busy=1.
REQ-019 In SW_ON, SHALL go to DRST on the first cycle sw_ack=1 is sampled; after ACK_TIMEOUT cycles without sw_ack=1, SHALL go to ERR.
REQ-020 In DRST, SHALL hold dom_rst_n=0 for RST_CYCLES cycles, release it to 1, then go to RESTORE.
REQ-021 In RESTORE, SHALL pulse restore=1 for exactly 1 cycle, then go to ISO_OFF.
REQ-022 In ISO_OFF, SHALL drive iso_en=0 and go to ON; in ON, pwr_on=1 and busy=0.
REQ-023 In ON with pwr_on_req=0 sampled, SHALL go to ISO_ON, asserting iso_en=1, busy=1 and pwr_on=0.
REQ-024 In ISO_ON, SHALL hold for ISO_SETUP cycles, then go to SAVE, which pulses save=1 for 1 cycle.
REQ-025 After SAVE, SHALL go to SW_OFF with top_pwr_sw=0 and dom_rst_n=0.
REQ-026 In SW_OFF, SHALL go to OFF on sw_ack=0 sampled; after ACK_TIMEOUT cycles without it, SHALL go to ERR.
REQ-027 SHALL ignore pwr_on_req changes while busy=1; a request that differs from the current state SHALL be acted on once ON or OFF is reached.
REQ-028 In ERR, SHALL drive top_pwr_sw=0, iso_en=1, dom_rst_n=0 and err=1.
REQ-029 In ERR, SHALL remain until err_clr=1, then go to OFF with err=0; err_clr outside ERR SHALL be ignored.
REQ-030 save and restore SHALL never both be 1, and SHALL never be 1 while iso_en=0.
REQ-031 SHALL size the timeout/hold counter to $clog2(max(ACK_TIMEOUT, RST_CYCLES, ISO_SETUP)+1) bits and reload it on every state entry.

Reset
REQ-032 rst_n=0 sampled SHALL force state OFF with top_pwr_sw=0, iso_en=1, dom_rst_n=0, save=0, restore=0, busy=0, pwr_on=0, err=0 and counter=0.
REQ-033 Reset mid-sequence SHALL abort immediately to the REQ-032 values, with no save or restore pulse.

Structure
REQ-034 A shared package pd_seq_pkg SHALL hold the state enum typedef and the parameter defaults.
REQ-035 A single sub-module pd_seq_timer (a loadable down-counter with a done flag) SHALL provide all hold and timeout counting.

Verification
REQ-036 Power-up: from reset, pwr_on_req=1 with sw_ack following top_pwr_sw after 3 cycles -> dom_rst_n low for 4 cycles, one restore pulse, iso_en falls, then pwr_on=1 and busy=0.
REQ-037 Power-down: from ON, pwr_on_req=0 -> iso_en=1 for 2 cycles before the save pulse, then top_pwr_sw=0, and OFF after sw_ack=0.
REQ-038 Timeout: pwr_on_req=1 with sw_ack held 0 -> err=1 and top_pwr_sw=0 after 64 cycles; err_clr pulse -> OFF with err=0.
REQ-039 Request toggle mid-sequence: pwr_on_req 1->0 during DRST -> power-up completes to ON, then power-down starts automatically.
REQ-040 Reset mid-sequence: rst_n=0 during SAVE or SW_ON -> all outputs at REQ-032 values on the next cycle.
REQ-041 Assertion over all tests: save and restore are never 1 while iso_en=0, and save and restore are never 1 together.
